sqrt_accel: RTL and testbench

Parametrised iterative integer square-root engine. It is the successor to the fixed 8-bit `raiz`/`controler` pair.
- Accepts an N-bit unsigned operand through a start/ready handshake.
- Produces one root bit per clock using the restoring digit-by-digit method.
- Reports root, truncated remainder and the cycle count spent.
- Adds an optional round-to-nearest mode.

Board tops drive it from switches and keys and show results on the 7-segment decoders.

---
 rtl/sqrt_pkg.sv | 16 +
 rtl/sqrt_step.sv | 25 ++
 rtl/sqrt_accel.sv | 110 +++++++++++
 tb/tb_sqrt_accel.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the iterative square-root engine.
package sqrt_pkg;

    typedef enum logic [1:0] {IDLE, ITER, RND, DONE} sqrt_state_t;

    // Root and remainder width. The extra MSB carries the rounding overflow.
    function automatic int root_width(input int n);
        return n / 2 + 1;
    endfunction

    // Width of the cycle counter output. It must hold n/2+1, the round-mode count.
    function automatic int cycle_width(input int n);
        return $clog2(n / 2 + 2);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration. Purely combinational.
module sqrt_step #(
    parameter int N = 16
) (
    input  logic [N/2+1:0] r,
    input  logic [N/2-1:0] q,
    input  logic [1:0]     bits,
    output logic [N/2+1:0] r_next,
    output logic [N/2-1:0] q_next
);

    logic [N/2+1:0] t;
    logic [N/2+1:0] d;
    logic           ge;

    // The partial remainder never exceeds 2q, so the trial value fits in N/2+2 bits.
    always_comb begin
        t      = (r << 2) | {{(N/2){1'b0}}, bits};
        d      = {q, 2'b01};
        ge     = (t >= d);
        r_next = ge ? (t - d) : t;
        q_next = (q << 1) | {{(N/2-1){1'b0}}, ge};
    end

endmodule

// File: rtl/sqrt_accel.sv
// Iterative integer square root: one root bit per clock, with optional round-to-nearest.
module sqrt_accel
    import sqrt_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      round,
    input  logic [N-1:0]              data_in,
    output logic                      ready,
    output logic                      done,
    output logic [root_width(N)-1:0]  root,
    output logic [root_width(N)-1:0]  remainder,
    output logic [cycle_width(N)-1:0] cycles
);

    localparam int H  = N / 2;
    localparam int RW = root_width(N);
    localparam int CW = cycle_width(N);
    localparam int KW = $clog2(H + 1);

    if ((N % 2) != 0 || N < 4) begin : g_bad_width
        $fatal(1, "sqrt_accel: N must be even and at least 4");
    end

    sqrt_state_t    state;
    logic [N-1:0]   x;
    logic [H+1:0]   r;
    logic [H+1:0]   r_next;
    logic [H-1:0]   q;
    logic [H-1:0]   q_next;
    logic [KW-1:0]  k;
    logic           round_q;

    sqrt_step #(.N(N)) u_step (
        .r      (r),
        .q      (q),
        .bits   (x[N-1:N-2]),
        .r_next (r_next),
        .q_next (q_next)
    );

    // NOTE: every register here is assigned with <= so each state update reads pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            root      <= '0;
            remainder <= '0;
            cycles    <= '0;
            x         <= '0;
            r         <= '0;
            q         <= '0;
            k         <= '0;
            round_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x       <= data_in;
                        round_q <= round;
                        k       <= KW'(H);
                        r       <= '0;
                        q       <= '0;
                        ready   <= 1'b0;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    r <= r_next;
                    q <= q_next;
                    x <= x << 2;
                    k <= k - KW'(1);
                    if (k == KW'(1)) begin
                        if (round_q) begin
                            state <= RND;
                        end else begin
                            root      <= {1'b0, q_next};
                            remainder <= r_next[RW-1:0];
                            cycles    <= CW'(H);
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RND: begin
                    // Round up when x >= q^2 + q + 1/4, which for integers means r > q.
                    root      <= {1'b0, q} + RW'(r > {2'b00, q});
                    remainder <= r[RW-1:0];
                    cycles    <= CW'(H + 1);
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_accel.sv
// Directed bench for sqrt_accel at N=8 and N=16 with hand-computed expected results.
module tb_sqrt_accel;

    logic        clock = 1'b0;
    logic        reset;
    logic        start8, start16;
    logic        round8, round16;
    logic [7:0]  data8;
    logic [15:0] data16;

    logic        ready8, done8, ready16, done16;
    logic [4:0]  root8, rem8;
    logic [2:0]  cyc8;
    logic [8:0]  root16, rem16;
    logic [3:0]  cyc16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sqrt_accel #(.N(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .round(round8), .data_in(data8),
        .ready(ready8), .done(done8), .root(root8), .remainder(rem8), .cycles(cyc8)
    );

    sqrt_accel #(.N(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .round(round16), .data_in(data16),
        .ready(ready16), .done(done16), .root(root16), .remainder(rem16), .cycles(cyc16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Single N=8 operation from a negedge; lat counts edges from capture to the done-raising edge.
    task automatic run8(input string tag, input logic [7:0] x, input logic rnd,
                        input int exp_root, input int exp_rem, input int exp_cyc, input int exp_lat);
        int lat;
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !ready8; i++) @(negedge clock);
        start8 = 1'b1; data8 = x; round8 = rnd;
        @(posedge clock); #1;
        start8 = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done8) begin got = 1; break; end
            @(posedge clock);
            lat++;
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_root"}, root8, exp_root);
        check({tag, "_rem"}, rem8, exp_rem);
        check({tag, "_cycles"}, cyc8, exp_cyc);
        check({tag, "_latency"}, lat, exp_lat);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, done8, 0);
        check({tag, "_ready_back"}, ready8, 1);
    endtask

    initial begin
        int done_at [2];
        int n_done;
        logic [4:0] roots [2];
        logic [4:0] rems [2];
        bit got;

        reset = 1'b1; start8 = 0; start16 = 0; round8 = 0; round16 = 0; data8 = 0; data16 = 0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready8", ready8, 1);
        check("rst_done8", done8, 0);
        check("rst_root8", root8, 0);
        check("rst_rem8", rem8, 0);
        check("rst_cyc8", cyc8, 0);
        check("rst_ready16", ready16, 1);
        check("rst_root16", root16, 0);

        run8("x144", 8'd144, 1'b0, 12, 0, 4, 5);

        // Results must hold across capture and ITER until the next completion.
        start8 = 1'b1; data8 = 8'd255; round8 = 1'b0;
        @(posedge clock); #1;
        start8 = 1'b0;
        @(negedge clock);
        check("hold_ready_low", ready8, 0);
        check("hold_root_in_iter", root8, 12);
        check("hold_cycles_in_iter", cyc8, 4);
        for (int i = 0; i < 10 && !done8; i++) @(negedge clock);
        check("x255_trunc_root", root8, 15);
        check("x255_trunc_rem", rem8, 30);
        check("x255_trunc_cyc", cyc8, 4);
        @(negedge clock);

        run8("x255_rnd", 8'd255, 1'b1, 16, 30, 5, 6);
        run8("x210_rnd", 8'd210, 1'b1, 14, 14, 5, 6);
        run8("x211_rnd", 8'd211, 1'b1, 15, 15, 5, 6);
        run8("x0_rnd",   8'd0,   1'b1, 0, 0, 5, 6);
        run8("x0_trunc", 8'd0,   1'b0, 0, 0, 4, 5);

        // N=16 full-scale operand.
        start16 = 1'b1; data16 = 16'hFFFF; round16 = 1'b0;
        @(posedge clock); #1;
        start16 = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done16) begin got = 1; break; end
        end
        check("n16_done_seen", got, 1);
        check("n16_root", root16, 255);
        check("n16_rem", rem16, 510);
        check("n16_cycles", cyc16, 8);

        // A start pulse during ITER must be ignored entirely.
        @(negedge clock); @(negedge clock);
        start8 = 1'b1; data8 = 8'd200; round8 = 1'b0;
        @(posedge clock); #1;
        start8 = 1'b0;
        @(posedge clock); #1;
        start8 = 1'b1; data8 = 8'd9;
        @(posedge clock); #1;
        start8 = 1'b0;
        n_done = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (done8) begin
                n_done++;
                if (n_done == 1) begin
                    check("ign_root", root8, 14);
                    check("ign_rem", rem8, 4);
                end
            end
        end
        check("ign_done_count", n_done, 1);
        check("ign_root_final", root8, 14);

        // start held high: the second operation is captured on the first IDLE cycle.
        start8 = 1'b1; data8 = 8'd200; round8 = 1'b0;
        @(posedge clock); #1;
        data8 = 8'd49;
        n_done = 0;
        done_at[0] = 0; done_at[1] = 0;
        roots[0] = '0; roots[1] = '0; rems[0] = '0; rems[1] = '0;
        for (int i = 1; i <= 30 && n_done < 2; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done8) begin
                done_at[n_done] = i;
                roots[n_done]   = root8;
                rems[n_done]    = rem8;
                n_done++;
            end
        end
        start8 = 1'b0;
        check("b2b_done_count", n_done, 2);
        check("b2b_first_at", done_at[0], 4);
        check("b2b_spacing", done_at[1] - done_at[0], 6);
        check("b2b_root1", roots[0], 14);
        check("b2b_rem1", rems[0], 4);
        check("b2b_root2", roots[1], 7);
        check("b2b_rem2", rems[1], 0);
        @(negedge clock);

        // Reset mid-ITER clears everything and never produces done.
        start8 = 1'b1; data8 = 8'd200; round8 = 1'b0;
        @(posedge clock); #1;
        start8 = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_ready", ready8, 1);
        check("mid_rst_done", done8, 0);
        check("mid_rst_root", root8, 0);
        check("mid_rst_rem", rem8, 0);
        check("mid_rst_cyc", cyc8, 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done8) n_done++;
        end
        check("mid_rst_no_done", n_done, 0);
        run8("x49_after_rst", 8'd49, 1'b0, 7, 0, 4, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
